// File: rtl/sig_halt_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : sig_halt_monitor_if
// Purpose  : Register-file writeback snoop bus seen by the halt monitor.
// Revision : 1.0 - initial release
// ============================================================================
interface sig_halt_monitor_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  wb_en;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0]     wb_data;

  modport master (output wb_en, output wb_rd, output wb_data);
  modport slave  (input  wb_en, input  wb_rd, input  wb_data);
endinterface
`default_nettype wire

// File: rtl/sig_halt_monitor.sv
`default_nettype none
// ============================================================================
// Module   : sig_halt_monitor
// Purpose  : End-of-test monitor: pass/fail signature and cycle timeout detect.
// Revision : 1.0 - initial release
// ============================================================================
module sig_halt_monitor #(
  parameter int          DATA_W     = 32,
  parameter int          REG_ADDR_W = 5,
  parameter int          NUM_SIG    = 2,
  parameter int          SIG_BASE   = 30,
  parameter logic [31:0] PASS_VAL   = 32'hBEEFBEEF,
  parameter logic [31:0] FAIL_VAL   = 32'hDEADDEAD,
  parameter int          TIMEOUT    = 1000,
  parameter int          CNT_W      = 32
) (
  input  wire logic               clk,
  input  wire logic               nrst,
  input  wire logic               arm,
  input  wire logic               clear,
  sig_halt_monitor_if.slave       wb,
  output logic                    halt,
  output logic                    pass,
  output logic                    fail,
  output logic                    timeout,
  output logic [NUM_SIG-1:0]      sig_hit,
  output logic [CNT_W-1:0]        cycle_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_PASS = 3'd2,
    S_FAIL = 3'd3,
    S_TOUT = 3'd4
  } state_t;

  localparam logic [DATA_W-1:0] c_pass_val = DATA_W'(PASS_VAL);
  localparam logic [DATA_W-1:0] c_fail_val = DATA_W'(FAIL_VAL);
  localparam logic [CNT_W-1:0]  c_tout_last = CNT_W'(TIMEOUT - 1);
  localparam bit                c_tout_en   = (TIMEOUT != 0);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [NUM_SIG-1:0]   r_sig_hit;
  logic [NUM_SIG-1:0]   w_sig_hit_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic                 w_fail_wr;
  logic                 r_halt;
  logic                 r_pass;
  logic                 r_fail;
  logic                 r_tout;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state   <= S_IDLE;
      r_sig_hit <= '0;
      r_cnt     <= '0;
      r_halt    <= 1'b0;
      r_pass    <= 1'b0;
      r_fail    <= 1'b0;
      r_tout    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_sig_hit <= w_sig_hit_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pass    <= (w_state_nxt == S_PASS);
      r_fail    <= (w_state_nxt == S_FAIL);
      r_tout    <= (w_state_nxt == S_TOUT);
      r_halt    <= (w_state_nxt == S_PASS) || (w_state_nxt == S_FAIL) ||
                   (w_state_nxt == S_TOUT);
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_sig_hit_nxt = r_sig_hit;
    w_cnt_nxt     = r_cnt;
    w_fail_wr     = 1'b0;

    if (clear) begin
      w_state_nxt   = S_IDLE;
      w_sig_hit_nxt = '0;
      w_cnt_nxt     = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_sig_hit_nxt = '0;
          w_cnt_nxt     = '0;
          if (arm) w_state_nxt = S_RUN;
        end
        S_RUN: begin
          if (r_cnt != '1) w_cnt_nxt = r_cnt + 1'b1;
          // Hit bits mirror register contents, so any non-pass write drops the bit.
          for (int i = 0; i < NUM_SIG; i++) begin
            if (wb.wb_en && (wb.wb_rd == REG_ADDR_W'(SIG_BASE + i))) begin
              w_sig_hit_nxt[i] = (wb.wb_data == c_pass_val);
              if (wb.wb_data == c_fail_val) w_fail_wr = 1'b1;
            end
          end
          if (w_fail_wr)
            w_state_nxt = S_FAIL;
          else if (&w_sig_hit_nxt)
            w_state_nxt = S_PASS;
          else if (c_tout_en && (r_cnt == c_tout_last))
            w_state_nxt = S_TOUT;
        end
        default: ;  // terminal states hold everything frozen
      endcase
    end
  end

  assign halt      = r_halt;
  assign pass      = r_pass;
  assign fail      = r_fail;
  assign timeout   = r_tout;
  assign sig_hit   = r_sig_hit;
  assign cycle_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sig_halt_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_sig_halt_monitor
// Purpose  : Directed self-checking bench for sig_halt_monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sig_halt_monitor;

  logic tb_clk = 1'b0;
  logic nrst   = 1'b0;
  logic arm    = 1'b0;
  logic clear  = 1'b0;

  logic        a_halt, a_pass, a_fail, a_tout;
  logic [1:0]  a_hit;
  logic [31:0] a_cnt;
  logic        b_halt, b_pass, b_fail, b_tout;
  logic [1:0]  b_hit;
  logic [31:0] b_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 tb_clk = ~tb_clk;

  sig_halt_monitor_if #(.DATA_W(32), .REG_ADDR_W(5)) wb_if ();

  sig_halt_monitor dut_a (
    .clk(tb_clk), .nrst(nrst), .arm(arm), .clear(clear), .wb(wb_if.slave),
    .halt(a_halt), .pass(a_pass), .fail(a_fail), .timeout(a_tout),
    .sig_hit(a_hit), .cycle_cnt(a_cnt)
  );

  sig_halt_monitor #(.TIMEOUT(20)) dut_b (
    .clk(tb_clk), .nrst(nrst), .arm(arm), .clear(clear), .wb(wb_if.slave),
    .halt(b_halt), .pass(b_pass), .fail(b_fail), .timeout(b_tout),
    .sig_hit(b_hit), .cycle_cnt(b_cnt)
  );

  task automatic tick();
    @(posedge tb_clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] rd, input logic [31:0] data);
    wb_if.wb_en   = 1'b1;
    wb_if.wb_rd   = rd;
    wb_if.wb_data = data;
    tick();
    wb_if.wb_en   = 1'b0;
    wb_if.wb_rd   = '0;
    wb_if.wb_data = '0;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Flags packed as {halt,pass,fail,timeout}
  task automatic check_a(input string tag, input logic [3:0] flags,
                         input logic [1:0] hit, input logic [31:0] cnt);
    check({tag, ".flags"}, {60'd0, a_halt, a_pass, a_fail, a_tout}, {60'd0, flags});
    check({tag, ".hit"},   {62'd0, a_hit}, {62'd0, hit});
    check({tag, ".cnt"},   {32'd0, a_cnt}, {32'd0, cnt});
  endtask

  task automatic check_b(input string tag, input logic [3:0] flags,
                         input logic [1:0] hit, input logic [31:0] cnt);
    check({tag, ".flags"}, {60'd0, b_halt, b_pass, b_fail, b_tout}, {60'd0, flags});
    check({tag, ".hit"},   {62'd0, b_hit}, {62'd0, hit});
    check({tag, ".cnt"},   {32'd0, b_cnt}, {32'd0, cnt});
  endtask

  initial begin
    wb_if.wb_en   = 1'b0;
    wb_if.wb_rd   = '0;
    wb_if.wb_data = '0;

    // Reset state
    #12;
    check_a("reset_a", 4'b0000, 2'b00, 32'd0);
    check_b("reset_b", 4'b0000, 2'b00, 32'd0);
    @(negedge tb_clk);
    nrst = 1'b1;
    tick();

    // 1: basic pass, count frozen after completion
    arm = 1'b1; tick(); arm = 1'b0;
    check_a("t1_run", 4'b0000, 2'b00, 32'd0);
    repeat (4) tick();
    wr(5'd30, 32'hBEEFBEEF);
    check_a("t1_x30", 4'b0000, 2'b01, 32'd5);
    repeat (3) tick();
    wr(5'd31, 32'hBEEFBEEF);
    check_a("t1_pass", 4'b1100, 2'b11, 32'd9);
    repeat (3) tick();
    check_a("t1_frozen", 4'b1100, 2'b11, 32'd9);
    clear = 1'b1; tick(); clear = 1'b0;
    check_a("t1_clear", 4'b0000, 2'b00, 32'd0);

    // 2: hit tracks register contents
    arm = 1'b1; tick(); arm = 1'b0;
    wr(5'd30, 32'hBEEFBEEF);
    check_a("t2_x30", 4'b0000, 2'b01, 32'd1);
    wr(5'd30, 32'h00000001);
    wr(5'd31, 32'hBEEFBEEF);
    check_a("t2_partial", 4'b0000, 2'b10, 32'd3);
    wr(5'd30, 32'hBEEFBEEF);
    check_a("t2_pass", 4'b1100, 2'b11, 32'd4);
    clear = 1'b1; tick(); clear = 1'b0;

    // 3: fail value on the completing register wins over pass
    arm = 1'b1; tick(); arm = 1'b0;
    wr(5'd30, 32'hBEEFBEEF);
    wr(5'd31, 32'hDEADDEAD);
    check_a("t3_fail", 4'b1010, 2'b01, 32'd2);
    wr(5'd31, 32'hBEEFBEEF);
    check_a("t3_sticky", 4'b1010, 2'b01, 32'd2);
    clear = 1'b1; tick(); clear = 1'b0;
    check_a("t3_clear", 4'b0000, 2'b00, 32'd0);

    // arm with clear in IDLE stays idle (counter would move in RUN)
    arm = 1'b1; clear = 1'b1; tick(); arm = 1'b0; clear = 1'b0;
    repeat (2) tick();
    check_a("armclr_idle", 4'b0000, 2'b00, 32'd0);

    // 4: timeout after exactly 20 RUN cycles (TIMEOUT=20 instance)
    clear = 1'b1; tick(); clear = 1'b0;
    arm = 1'b1; tick(); arm = 1'b0;
    check_b("t4_start", 4'b0000, 2'b00, 32'd0);
    repeat (19) tick();
    check_b("t4_pre", 4'b0000, 2'b00, 32'd19);
    tick();
    check_b("t4_tout", 4'b1001, 2'b00, 32'd20);
    check_a("t4_a_running", 4'b0000, 2'b00, 32'd20);
    repeat (2) tick();
    check_b("t4_frozen", 4'b1001, 2'b00, 32'd20);
    clear = 1'b1; tick(); clear = 1'b0;
    check_b("t4_clear", 4'b0000, 2'b00, 32'd0);
    check_a("t4_a_clear", 4'b0000, 2'b00, 32'd0);

    // 5: writes in IDLE and to non-signature registers are ignored
    wr(5'd30, 32'hBEEFBEEF);
    wr(5'd31, 32'hBEEFBEEF);
    check_a("t5_idle", 4'b0000, 2'b00, 32'd0);
    arm = 1'b1; tick(); arm = 1'b0;
    wr(5'd0, 32'hBEEFBEEF);
    wr(5'd29, 32'hBEEFBEEF);
    check_a("t5_nonsig", 4'b0000, 2'b00, 32'd2);

    // 6: async reset mid-RUN drops partial hits
    wr(5'd30, 32'hBEEFBEEF);
    check_a("t6_hit", 4'b0000, 2'b01, 32'd3);
    #2 nrst = 1'b0;
    #1;
    check_a("t6_async", 4'b0000, 2'b00, 32'd0);
    @(negedge tb_clk);
    nrst = 1'b1;
    tick();
    arm = 1'b1; tick(); arm = 1'b0;
    wr(5'd31, 32'hBEEFBEEF);
    check_a("t6_rearm", 4'b0000, 2'b10, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
